// File: rtl/clk_divider.sv
// Programmable integer clock divider / tick generator fed by the free-running clk from clock_gen.
// Ports: clk_i/rst_i (async active-high), en_i freezes the divider, div_i requested ratio N,
//        clk_out_o registered square wave, tick_o one-cycle period pulse, cnt_o position 0..N-1,
//        div_active_o ratio currently in effect.
// Latency: all outputs registered; a new ratio is adopted only on a wrap edge. No backpressure.
module clk_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] div_active_o
);

  localparam logic [WIDTH-1:0] ONE_N  = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO_N  = WIDTH'(2);
  localparam logic [WIDTH:0]   ONE_W  = (WIDTH+1)'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [WIDTH:0]   half;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap;

  // HALF is carried one bit wider so that N = 2^WIDTH-1 rounds up without wrapping to 0.
  assign half    = ({1'b0, div_q} + ONE_W) >> 1;
  // In the no-wrap branch cnt <= N-2, so this increment can never overflow.
  assign cnt_nxt = cnt_q + ONE_N;
  // Ratios 0 and 1 wrap every enabled edge (pass-through tick mode).
  assign wrap    = (div_q < TWO_N) || (cnt_q == (div_q - ONE_N));

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (en_i) begin
      if (wrap) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        div_d     = div_i;
        clk_out_d = (div_i >= TWO_N);
      end else begin
        cnt_d     = cnt_nxt;
        clk_out_d = ({1'b0, cnt_nxt} < half);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      div_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o    = clk_out_q;
  assign tick_o       = tick_q;
  assign cnt_o        = cnt_q;
  assign div_active_o = div_q;

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider: a reference model pushes the expected outputs for each
// driven edge into a queue, and each scenario task pops and compares after the edge.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_clk_divider;
  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         en_i  = 1'b0;
  logic [W-1:0] div_i = '0;
  logic         clk_out_o;
  logic         tick_o;
  logic [W-1:0] cnt_o;
  logic [W-1:0] div_active_o;

  clk_divider #(.WIDTH(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .div_i       (div_i),
    .clk_out_o   (clk_out_o),
    .tick_o      (tick_o),
    .cnt_o       (cnt_o),
    .div_active_o(div_active_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic         clk_out;
    logic         tick;
    logic [W-1:0] cnt;
    logic [W-1:0] div_active;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state (plain integers).
  int   m_cnt, m_n;
  logic m_clk, m_tick;

  function automatic string show(input obs_t o);
    return $sformatf("clk_out=%0b tick=%0b cnt=%0d div_active=%0d",
                     o.clk_out, o.tick, o.cnt, o.div_active);
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = {clk_out_o, tick_o, cnt_o, div_active_o};
    return o;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_n    = 0;
    m_clk  = 1'b0;
    m_tick = 1'b0;
    exp_q.delete();
  endtask

  // Drive one edge's inputs, predict the outcome, push it, and advance past the edge.
  task automatic step(input logic en, input int div);
    obs_t e;
    en_i  = en;
    div_i = W'(div);
    if (en) begin
      if (m_n < 2 || m_cnt == m_n - 1) begin
        m_cnt  = 0;
        m_tick = 1'b1;
        m_n    = div;
        m_clk  = (div >= 2);
      end else begin
        m_cnt  = m_cnt + 1;
        m_tick = 1'b0;
        m_clk  = (m_cnt < (m_n + 1) / 2);
      end
    end else begin
      m_tick = 1'b0;
    end
    e = {m_clk, m_tick, W'(m_cnt), W'(m_n)};
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    en_i  = 1'b0;
    div_i = '0;
    #3;
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    obs_t got;
    rst_i = 1'b1;
    en_i  = 1'b1;
    div_i = W'(4);
    #1;
    got = observe();
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got %s, want all zero", show(got));
    end
    @(posedge clk_i);
    #1;
    got = observe();
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset_hold_over_edge: got %s, want all zero", show(got));
    end
    rst_i = 1'b0;
    en_i  = 1'b0;
    model_reset();
  endtask

  task automatic test_div4();
    obs_t got, want;
    int ticks = 0;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 4);
      got = observe();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL div4 edge %0d: got %s, want %s", i, show(got), show(want));
      end
      if (got.tick) ticks++;
    end
    n_cmp++;
    if (ticks !== 3) begin
      n_bad++;
      $display("FAIL div4_tick_count: got %0d, want 3", ticks);
    end
  endtask

  task automatic test_div5();
    obs_t got, want;
    int highs = 0;
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, 5);
      got = observe();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL div5 edge %0d: got %s, want %s", i, show(got), show(want));
      end
      if (got.clk_out) highs++;
    end
    n_cmp++;
    if (highs !== 9) begin
      n_bad++;
      $display("FAIL div5_high_cycles: got %0d, want 9", highs);
    end
  endtask

  // Ratio changes 4 -> 6 after cnt=1; the 4-period finishes, 6 loads on edge 5, next tick edge 11.
  task automatic test_ratio_change();
    obs_t got, want;
    int last_tick = 0;
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      step(1'b1, (i <= 2) ? 4 : 6);
      got = observe();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL ratio_change edge %0d: got %s, want %s", i, show(got), show(want));
      end
      if (got.tick) last_tick = i;
    end
    n_cmp++;
    if (last_tick !== 11) begin
      n_bad++;
      $display("FAIL ratio_change_last_tick: got edge %0d, want edge 11", last_tick);
    end
  endtask

  task automatic test_en_hold();
    obs_t got, want;
    logic en_seq [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(en_seq[i], 4);
      got = observe();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL en_hold edge %0d: got %s, want %s", i + 1, show(got), show(want));
      end
    end
  endtask

  task automatic test_passthrough();
    obs_t got, want;
    int   div_seq [6] = '{0, 0, 0, 1, 1, 1};
    logic en_seq  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(en_seq[i], div_seq[i]);
      got = observe();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL passthrough edge %0d: got %s, want %s", i + 1, show(got), show(want));
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t got, want;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 8);
      void'(exp_q.pop_front());
    end
    n_cmp++;
    if (cnt_o !== W'(3)) begin
      n_bad++;
      $display("FAIL async_reset_precond: got cnt=%0d, want cnt=3", cnt_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    got = observe();
    n_cmp++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL async_reset_midcycle: got %s, want all zero", show(got));
    end
    rst_i = 1'b0;
    model_reset();
    step(1'b1, 8);
    got = observe();
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL async_reset_first_edge: got %s, want %s", show(got), show(want));
    end
  endtask

  task automatic test_max_ratio();
    obs_t got, want;
    int highs = 0;
    int ticks = 0;
    int max_cnt = 0;
    int shown = 0;
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      step(1'b1, 255);
      got = observe();
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        if (shown < 5) $display("FAIL max_ratio edge %0d: got %s, want %s", i, show(got), show(want));
        shown++;
      end
      if (i <= 255 && got.clk_out) highs++;
      if (got.tick) ticks++;
      if (int'(got.cnt) > max_cnt) max_cnt = int'(got.cnt);
    end
    n_cmp++;
    if (highs !== 128) begin
      n_bad++;
      $display("FAIL max_ratio_high_cycles: got %0d, want 128", highs);
    end
    n_cmp++;
    if (max_cnt !== 254) begin
      n_bad++;
      $display("FAIL max_ratio_max_cnt: got %0d, want 254", max_cnt);
    end
    n_cmp++;
    if (ticks !== 2) begin
      n_bad++;
      $display("FAIL max_ratio_tick_count: got %0d, want 2", ticks);
    end
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div5();
    test_ratio_change();
    test_en_hold();
    test_passthrough();
    test_async_reset();
    test_max_ratio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_divider.md
Name: clk_divider

Overview:
Programmable integer clock divider and tick generator, placed directly downstream of clock_gen. It consumes the free-running clk from clock_gen and produces a divided clock-enable-style square wave and a one-cycle period tick for slower logic such as LED blinkers and stopwatch counters. All outputs are registered and synchronous to clk; no derived clock drives flop clock pins.

Parameters:
WIDTH, 8, width of the divide ratio and of the internal counter.

Ports:
clk  input  1  system clock from clock_gen
rst  input  1  reset, asynchronous, active-high
en  input  1  count enable; 0 freezes the divider
div  input  WIDTH  requested divide ratio N; sampled only at period boundaries
clk_out  output  1  divided square wave, registered
tick  output  1  one-clk-cycle pulse at the start of each period
cnt  output  WIDTH  current position within the period, 0..N-1
div_active  output  WIDTH  divide ratio currently in effect

Behaviour:
- Reset is asynchronous and active-high: clk and a single asynchronous active-high reset are the only clock and reset.
  - On reset assertion, immediately: cnt=0, clk_out=0, tick=0, div_active=0.
  - Reset asserted mid-period aborts the period; the first enabled edge after release behaves as a wrap (below).
- Let N = div_active and HALF = (N+1)>>1, computed at WIDTH+1 bits so N=2^WIDTH-1 does not overflow.
- Rising clk edge with en=0: cnt, clk_out and div_active hold; tick<=0.
- Rising clk edge with en=1, wrap condition (N<2, or cnt==N-1):
  - cnt<=0
  - tick<=1
  - div_active<=div (new ratio sampled here and only here)
  - clk_out<=1 if the newly loaded div>=2, else 0
- Rising clk edge with en=1, no wrap:
  - cnt<=cnt+1
  - tick<=0
  - clk_out<=((cnt+1) < HALF)
  - div_active holds.
- Invariant after any edge with div_active>=2: clk_out == (cnt < HALF).
  - For div=N>=2, clk_out is high for HALF cycles and low for N-HALF cycles.
  - Even N gives 50% duty; odd N is high one cycle longer.
- N<2 (div 0 or 1): pass-through tick mode.
  - tick is high every enabled cycle; cnt=0, clk_out=0.
- Latency:
  - div_active is 0 after reset, so the first enabled edge always wraps: tick=1, div loaded.
  - The ratio change therefore takes effect on the first enabled edge after reset.
- Changes on div mid-period are ignored until the next wrap edge; the current period completes with the old N.
- en deasserted across a wrap point: the wrap happens on the next enabled edge. tick never fires while en=0 and never lasts more than one cycle per period.
- Maximum ratio 2^WIDTH-1: cnt counts 0..2^WIDTH-2; no counter overflow is possible.
- Simultaneous wrap and div change on the same edge: the div value present at that edge is loaded.

Test Plan:
- Reset, div=4, en=1: edges 1..9 give cnt 0,1,2,3,0,1,2,3,0; clk_out 1,1,0,0,1,1,0,0,1; tick 1,0,0,0,1,0,0,0,1; div_active=4 from edge 1.
- div=5, en=1 from reset: clk_out pattern 1,1,1,0,0 repeating; tick every 5th edge; cnt max 4.
- Period running with div=4, div changed to 6 at cnt=1: remaining cnt 2,3, then wrap with div_active=6. Next tick occurs 6 edges later; clk_out high 3 cycles, low 3 cycles.
- div=4, en dropped for 3 cycles at cnt=2: cnt stays 2, clk_out stays 0, tick stays 0. After en=1, cnt goes 3,0 and tick fires on the 0.
- div=0, then div=1: tick=1 on every enabled edge; clk_out=0; cnt=0. With en toggling 1,0,1, tick goes 1,0,1.
- Async rst pulse between edges at cnt=3, div=8, then release: outputs go 0 immediately without a clk edge. The first enabled edge gives tick=1, cnt=0, div_active=8.
- WIDTH=8, div=255: cnt reaches 254 then 0; tick period is 255 edges; clk_out high for 128, low for 127.
